// File: rtl/bpu_bht.sv
// rtl/bpu_bht.sv - 2-bit saturating counter branch history table with zero-latency prediction
// Define BPU_GSHARE_EN to XOR the global history register into the table index.
module bpu_bht #(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int GHR_LEN   = 6,
  localparam int IDXW     = $clog2(BHT_DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_stop,
  input  logic               i_prdt_vld,
  input  logic [XLEN-1:0]    i_pc,
  input  logic               i_inst_jal,
  input  logic               i_inst_jalr,
  input  logic               i_inst_bxx,
  input  logic               i_jalr_rs1ren,
  input  logic [XLEN-1:0]    i_imm,
  input  logic [XLEN-1:0]    i_jalr_rs1rdata,
  output logic               o_prdt_taken,
  output logic [XLEN-1:0]    o_prdt_pc,
  output logic [IDXW-1:0]    o_prdt_idx,
  output logic [GHR_LEN-1:0] o_prdt_ghr,
  input  logic               i_upd_vld,
  input  logic [IDXW-1:0]    i_upd_idx,
  input  logic               i_upd_taken,
  input  logic               i_upd_mispredict,
  input  logic [GHR_LEN-1:0] i_upd_ghr
);

  logic [1:0]         cnt_q [BHT_DEPTH];
  logic [1:0]         cnt_d [BHT_DEPTH];
  logic [GHR_LEN-1:0] ghr_q;
  logic [GHR_LEN-1:0] ghr_d;
  logic [IDXW-1:0]    base_idx;
  logic [XLEN-1:0]    jalr_base;
  logic [XLEN-1:0]    jalr_sum;

  assign base_idx = i_pc[IDXW+1:2];

`ifdef BPU_GSHARE_EN
  assign o_prdt_idx = base_idx ^ IDXW'(ghr_q);

  function automatic logic [GHR_LEN-1:0] ghr_push(input logic [GHR_LEN-1:0] h, input logic b);
    return GHR_LEN'({h, b});
  endfunction

  // A mispredict restore comes last so it overrides the speculative shift.
  always_comb begin
    ghr_d = ghr_q;
    if (i_prdt_vld && i_inst_bxx && !i_stop && !i_upd_mispredict)
      ghr_d = ghr_push(ghr_q, o_prdt_taken);
    if (i_upd_vld && i_upd_mispredict)
      ghr_d = ghr_push(i_upd_ghr, i_upd_taken);
  end
`else
  logic unused_ghr_inputs;

  assign o_prdt_idx        = base_idx;
  assign unused_ghr_inputs = ^{i_upd_ghr, i_upd_mispredict, i_stop};

  always_comb begin
    ghr_d = '0;
  end
`endif

  assign o_prdt_ghr = ghr_q;

  always_comb begin
    jalr_base    = i_jalr_rs1ren ? i_jalr_rs1rdata : '0;
    jalr_sum     = jalr_base + i_imm;
    o_prdt_taken = i_prdt_vld & (i_inst_jal | i_inst_jalr | (i_inst_bxx & cnt_q[o_prdt_idx][1]));
    if (i_inst_jalr)
      o_prdt_pc = {jalr_sum[XLEN-1:1], 1'b0};
    else
      o_prdt_pc = i_pc + i_imm;
  end

  // Reads above see cnt_q, so a same-cycle update to the read index is not bypassed.
  always_comb begin
    cnt_d = cnt_q;
    if (i_upd_vld) begin
      if (i_upd_taken && cnt_q[i_upd_idx] != 2'b11)
        cnt_d[i_upd_idx] = cnt_q[i_upd_idx] + 2'b01;
      else if (!i_upd_taken && cnt_q[i_upd_idx] != 2'b00)
        cnt_d[i_upd_idx] = cnt_q[i_upd_idx] - 2'b01;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) cnt_q[i] <= 2'b01;
      ghr_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      ghr_q <= ghr_d;
    end
  end

endmodule

// File: tb/tb_bpu_bht.sv
// tb/tb_bpu_bht.sv - randomized self-checking bench for bpu_bht against a table/history model
module tb_bpu_bht;
  localparam int DEPTH = 64;
  localparam int GMASK = 63;
`ifdef BPU_GSHARE_EN
  localparam bit GSHARE = 1'b1;
`else
  localparam bit GSHARE = 1'b0;
`endif

  logic        i_clk, i_rst, i_stop, i_prdt_vld;
  logic [31:0] i_pc, i_imm, i_jalr_rs1rdata;
  logic        i_inst_jal, i_inst_jalr, i_inst_bxx, i_jalr_rs1ren;
  logic        o_prdt_taken;
  logic [31:0] o_prdt_pc;
  logic [5:0]  o_prdt_idx, o_prdt_ghr;
  logic        i_upd_vld, i_upd_taken, i_upd_mispredict;
  logic [5:0]  i_upd_idx, i_upd_ghr;

  int n_checks = 0;
  int n_errors = 0;
  int cnt_m [DEPTH];
  int ghr_m;

  bpu_bht dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_stop(i_stop), .i_prdt_vld(i_prdt_vld),
    .i_pc(i_pc), .i_inst_jal(i_inst_jal), .i_inst_jalr(i_inst_jalr), .i_inst_bxx(i_inst_bxx),
    .i_jalr_rs1ren(i_jalr_rs1ren), .i_imm(i_imm), .i_jalr_rs1rdata(i_jalr_rs1rdata),
    .o_prdt_taken(o_prdt_taken), .o_prdt_pc(o_prdt_pc), .o_prdt_idx(o_prdt_idx),
    .o_prdt_ghr(o_prdt_ghr), .i_upd_vld(i_upd_vld), .i_upd_idx(i_upd_idx),
    .i_upd_taken(i_upd_taken), .i_upd_mispredict(i_upd_mispredict), .i_upd_ghr(i_upd_ghr)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int exp_idx();
    int base;
    base = int'((i_pc >> 2) & 32'(DEPTH - 1));
    return GSHARE ? (base ^ ghr_m) : base;
  endfunction

  function automatic bit exp_taken();
    if (!i_prdt_vld) return 1'b0;
    if (i_inst_jal || i_inst_jalr) return 1'b1;
    return i_inst_bxx && (cnt_m[exp_idx()] >= 2);
  endfunction

  function automatic logic [31:0] exp_pc();
    logic [31:0] s;
    if (i_inst_jalr) begin
      s = (i_jalr_rs1ren ? i_jalr_rs1rdata : 32'd0) + i_imm;
      return s & 32'hFFFF_FFFE;
    end
    return i_pc + i_imm;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) cnt_m[i] = 1;
    ghr_m = 0;
  endtask

  task automatic idle();
    i_stop = 0; i_prdt_vld = 0; i_pc = 0; i_imm = 0; i_jalr_rs1rdata = 0;
    i_inst_jal = 0; i_inst_jalr = 0; i_inst_bxx = 0; i_jalr_rs1ren = 0;
    i_upd_vld = 0; i_upd_taken = 0; i_upd_mispredict = 0; i_upd_idx = 0; i_upd_ghr = 0;
  endtask

  task automatic bxx(input logic [31:0] pc, input logic [31:0] imm);
    i_prdt_vld = 1; i_inst_bxx = 1; i_inst_jal = 0; i_inst_jalr = 0; i_pc = pc; i_imm = imm;
  endtask

  task automatic upd(input int idx, input bit taken);
    i_upd_vld = 1; i_upd_idx = 6'(idx); i_upd_taken = taken;
  endtask

  task automatic check_pred(input string tag);
    #1;
    check({tag, ".taken"}, o_prdt_taken, exp_taken());
    if (i_prdt_vld && (i_inst_jal || i_inst_jalr || i_inst_bxx))
      check({tag, ".pc"}, o_prdt_pc, exp_pc());
    check({tag, ".idx"}, o_prdt_idx, exp_idx());
    check({tag, ".ghr"}, o_prdt_ghr, ghr_m);
  endtask

  task automatic tick();
    bit t;
    int g;
    int c;
    t = exp_taken();
    g = ghr_m;
    if (GSHARE) begin
      if (i_prdt_vld && i_inst_bxx && !i_stop && !i_upd_mispredict) g = ((ghr_m << 1) | int'(t)) & GMASK;
      if (i_upd_vld && i_upd_mispredict) g = ((int'(i_upd_ghr) << 1) | int'(i_upd_taken)) & GMASK;
    end
    @(posedge i_clk);
    if (!i_rst) begin
      if (i_upd_vld) begin
        c = cnt_m[i_upd_idx];
        cnt_m[i_upd_idx] = i_upd_taken ? ((c == 3) ? 3 : c + 1) : ((c == 0) ? 0 : c - 1);
      end
      ghr_m = g;
    end
    @(negedge i_clk);
    #1;
  endtask

  initial begin
    int r;
    idle();
    i_rst = 1;
    model_reset();
    bxx(32'h100, 32'h20);
    check_pred("rst_state");
    check("rst_taken", o_prdt_taken, 1'b0);
    check("rst_ghr", o_prdt_ghr, 6'd0);
    upd(0, 1);
    tick();
    i_rst = 0;
    idle();

    // Basic bxx after reset; the update pending during reset must have been dropped.
    bxx(32'h100, 32'h20);
    check_pred("bxx_rst");
    check("bxx_rst.taken", o_prdt_taken, 1'b0);
    check("bxx_rst.pc", o_prdt_pc, 32'h120);
    check("bxx_rst.idx", o_prdt_idx, 6'h00);
    tick();
    idle();

    upd(0, 1); tick();
    upd(0, 1); tick();
    idle();
    bxx(32'h100, 32'h20); i_stop = 1;
    check_pred("sat_a");
    check("sat_a.taken", o_prdt_taken, 1'b1);
    tick();
    idle();
    for (int i = 0; i < 5; i++) begin upd(0, 1); tick(); end
    upd(0, 0); tick();
    idle();
    bxx(32'h100, 32'h20); i_stop = 1;
    check_pred("sat_b");
    check("sat_b.taken", o_prdt_taken, 1'b1);

    idle();
    i_prdt_vld = 1; i_inst_jalr = 1; i_jalr_rs1ren = 1; i_jalr_rs1rdata = 32'h2001; i_imm = 32'h4;
    check_pred("jalr_a");
    check("jalr_a.pc", o_prdt_pc, 32'h2004);
    check("jalr_a.taken", o_prdt_taken, 1'b1);
    i_jalr_rs1ren = 0; i_imm = 32'h81;
    check_pred("jalr_b");
    check("jalr_b.pc", o_prdt_pc, 32'h80);
    idle();
    i_prdt_vld = 1; i_inst_jal = 1; i_pc = 32'h1000; i_imm = 32'hFFFF_FFF8;
    check_pred("jal");
    check("jal.pc", o_prdt_pc, 32'hFF8);
    i_prdt_vld = 0;
    check_pred("novld");
    i_prdt_vld = 1; i_inst_jal = 0;
    check_pred("notype");
    idle();

    // Same-cycle read and update of index 5 returns the pre-update counter.
    #1 i_rst = 1; model_reset();
    #1 i_rst = 0;
    bxx(32'h14, 32'h8); upd(5, 1);
    check_pred("nobyp_a");
    check("nobyp_a.taken", o_prdt_taken, 1'b0);
    tick();
    idle();
    bxx(32'h14, 32'h8); i_stop = 1;
    check_pred("nobyp_b");
    check("nobyp_b.taken", o_prdt_taken, 1'b1);
    idle();
    upd(5, 1); tick();
    upd(6, 1); tick();
    upd(6, 1); tick();
    idle();
    bxx(32'h14, 32'h0); i_stop = 1;
    check_pred("pre_rst");

    // Asynchronous reset between edges takes effect without a clock.
    #1 i_rst = 1; model_reset();
    check_pred("async_rst5");
    check("async_rst5.taken", o_prdt_taken, 1'b0);
    i_pc = 32'h18;
    check_pred("async_rst6");
    check("async_rst6.taken", o_prdt_taken, 1'b0);
    check("async_rst.ghr", o_prdt_ghr, 6'd0);
    #1 i_rst = 0;
    idle();

`ifdef BPU_GSHARE_EN
    bxx(32'h40, 32'h4); tick();
    bxx(32'h80, 32'h4); tick();
    bxx(32'hC0, 32'h4); check_pred("gs_nt"); tick();
    check("gs_ghr0", o_prdt_ghr, 6'd0);
    bxx(32'h200, 32'h4);
    i_upd_vld = 1; i_upd_idx = 6'd10; i_upd_taken = 1; i_upd_mispredict = 1; i_upd_ghr = 6'b000011;
    check_pred("gs_mis");
    tick();
    idle();
    check("gs_ghr7", o_prdt_ghr, 6'b000111);
    bxx(32'h104, 32'h4);
    check_pred("gs_idx");
    check("gs_idx6", o_prdt_idx, 6'h06);
    tick();
    idle();
`endif

    for (int n = 0; n < 400; n++) begin
      idle();
      i_prdt_vld = ($urandom_range(0, 9) < 7);
      r = $urandom_range(0, 4);
      i_inst_jal = (r == 1); i_inst_jalr = (r == 2); i_inst_bxx = (r >= 3);
      i_pc = $urandom_range(0, 31) << 2;
      if ($urandom_range(0, 3) == 0) i_pc = $urandom;
      i_imm = $urandom; i_jalr_rs1ren = 1'($urandom); i_jalr_rs1rdata = $urandom;
      i_stop = ($urandom_range(0, 4) == 0);
      i_upd_vld = 1'($urandom);
      i_upd_idx = 6'($urandom_range(0, 31));
      i_upd_taken = 1'($urandom);
      i_upd_mispredict = ($urandom_range(0, 3) == 0);
      i_upd_ghr = 6'($urandom);
      check_pred("rand");
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
